// File: rtl/mm_master_pkg.sv
// Shared types and constants for the burstless Avalon-MM write master.
package mm_master_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wm_state_t;

    localparam int         WORD_BYTES     = 4;
    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/mm_wr_fifo.sv
// Show-ahead FIFO buffering user write words ahead of the Avalon write beats.
module mm_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Head is masked while empty so the write data bus reads zero after reset.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mm_burstless_write_master.sv
// Avalon-MM write master: one single-beat word write per buffered user word
// until the commanded byte length is consumed.
module mm_burstless_write_master
    import mm_master_pkg::*;
#(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]     control_write_base,
    input  logic [ADDRESSWIDTH-1:0]     control_write_length,
    input  logic                        control_go,
    output logic                        control_done,
    input  logic                        user_write_buffer,
    input  logic [DATAWIDTH-1:0]        user_buffer_data,
    output logic                        user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]     master_address,
    output logic                        master_write,
    output logic [3:0]                  master_byteenable,
    output logic [DATAWIDTH-1:0]        master_writedata,
    input  logic                        master_waitrequest,
    output wm_state_t                   dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count
);
    localparam int AW = ADDRESSWIDTH;
    localparam int WW = ADDRESSWIDTH - 2;

    wm_state_t     state_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [WW-1:0] words_q;
    logic          fixed_q;
    logic          fifo_empty;
    logic          beat_accept;
    logic          unused_low_bits;

    assign unused_low_bits = ^{control_write_base[1:0], control_write_length[1:0]};

    // Handshake: a beat transfers on any cycle where master_write is high and
    // master_waitrequest is low; address and data only move on such a cycle,
    // so they hold stable for the whole stall.
    assign master_write      = (state_q == RUN) && !fifo_empty;
    assign beat_accept       = master_write && !master_waitrequest;
    assign master_address    = addr_q;
    assign master_byteenable = BYTEENABLE_ALL;
    assign control_done      = (state_q == IDLE);
    assign dbg_state         = state_q;
    assign addr_d            = addr_q + AW'(WORD_BYTES);

    mm_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATAWIDTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (user_write_buffer),
        .pop   (beat_accept),
        .din   (user_buffer_data),
        .dout  (master_writedata),
        .full  (user_buffer_full),
        .empty (fifo_empty),
        .count (dbg_fifo_count)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            words_q <= '0;
            fixed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A command shorter than one word carries no work and is dropped.
                    if (control_go && (control_write_length[AW-1:2] != '0)) begin
                        addr_q  <= {control_write_base[AW-1:2], 2'b00};
                        words_q <= control_write_length[AW-1:2];
                        fixed_q <= control_fixed_location;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (beat_accept) begin
                        words_q <= words_q - WW'(1);
                        if (!fixed_q) addr_q <= addr_d;
                        if (words_q == WW'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_burstless_write_master.sv
// Directed bench for mm_burstless_write_master with a beat scoreboard.
module tb_mm_burstless_write_master;
    import mm_master_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        control_fixed_location;
    logic [27:0] control_write_base;
    logic [27:0] control_write_length;
    logic        control_go;
    logic        control_done;
    logic        user_write_buffer;
    logic [31:0] user_buffer_data;
    logic        user_buffer_full;
    logic [27:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    wm_state_t   dbg_state;
    logic [4:0]  dbg_fifo_count;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int acc_start;

    logic [59:0] exp_q[$];

    mm_burstless_write_master #(
        .ADDRESSWIDTH (28),
        .DATAWIDTH    (32),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .master_address         (master_address),
        .master_write           (master_write),
        .master_byteenable      (master_byteenable),
        .master_writedata       (master_writedata),
        .master_waitrequest     (master_waitrequest),
        .dbg_state              (dbg_state),
        .dbg_fifo_count         (dbg_fifo_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the head of exp_q.
    always @(negedge clk) begin
        logic [59:0] e;
        if (n_rst && master_write && !master_waitrequest) begin
            acc_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("beat_addr", {4'h0, master_address}, {4'h0, e[59:32]});
                check("beat_data", master_writedata, e[31:0]);
                check("beat_be", {28'h0, master_byteenable}, 32'hF);
            end
        end
    end

    // Driver tasks
    task automatic exp_push(input logic [27:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push1(input logic [31:0] d);
        user_write_buffer = 1'b1;
        user_buffer_data  = d;
        @(posedge clk);
        #1;
        user_write_buffer = 1'b0;
    endtask

    task automatic go(input logic [27:0] base, input logic [27:0] len, input logic fixed);
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        @(posedge clk);
        #1;
        control_go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (control_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'h0, control_done}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},  {31'h0, control_done}, 32'd1);
        check({tag, "_write"}, {31'h0, master_write}, 32'd0);
        check({tag, "_full"},  {31'h0, user_buffer_full}, 32'd0);
        check({tag, "_addr"},  {4'h0, master_address}, 32'd0);
        check({tag, "_wdata"}, master_writedata, 32'd0);
        check({tag, "_state"}, {31'h0, dbg_state}, {31'h0, IDLE});
        check({tag, "_count"}, {27'h0, dbg_fifo_count}, 32'd0);
    endtask

    initial begin
        n_rst                  = 1'b0;
        control_fixed_location = 1'b0;
        control_write_base     = '0;
        control_write_length   = '0;
        control_go             = 1'b0;
        user_write_buffer      = 1'b0;
        user_buffer_data       = '0;
        master_waitrequest     = 1'b0;

        #12;
        check_idle_outputs("rst");
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Basic transfer
        for (int i = 0; i < 4; i++) begin
            exp_push(28'h100 + 28'(4 * i), 32'h11 * (i + 1));
            push1(32'h11 * (i + 1));
        end
        @(negedge clk);
        check("basic_prefill", {27'h0, dbg_fifo_count}, 32'd4);
        acc_start = acc_cnt;
        go(28'h100, 28'd16, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("basic_write", {31'h0, master_write}, 32'd1);
            check("basic_busy", {31'h0, control_done}, 32'd0);
        end
        @(negedge clk);
        check("basic_done_rise", {31'h0, control_done}, 32'd1);
        check("basic_write_low", {31'h0, master_write}, 32'd0);
        check("basic_beats", acc_cnt - acc_start, 32'd4);
        check("basic_q_empty", exp_q.size(), 32'd0);

        // Waitrequest stall on beat 2
        for (int i = 0; i < 4; i++) begin
            exp_push(28'h100 + 28'(4 * i), 32'h11 * (i + 1));
            push1(32'h11 * (i + 1));
        end
        acc_start = acc_cnt;
        go(28'h100, 28'd16, 1'b0);
        @(posedge clk);
        #1;
        master_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_addr", {4'h0, master_address}, 32'h104);
            check("stall_data", master_writedata, 32'h22);
            check("stall_write", {31'h0, master_write}, 32'd1);
        end
        @(posedge clk);
        #1;
        master_waitrequest = 1'b0;
        wait_done("stall", 20);
        check("stall_beats", acc_cnt - acc_start, 32'd4);

        // Fixed location with truncated base and length
        exp_push(28'h0F0, 32'hA1);
        push1(32'hA1);
        exp_push(28'h0F0, 32'hA2);
        push1(32'hA2);
        acc_start = acc_cnt;
        go(28'h0F3, 28'd11, 1'b1);
        wait_done("fixed", 20);
        check("fixed_beats", acc_cnt - acc_start, 32'd2);

        // FIFO fill to full, overflow drop, push/pop at full
        for (int i = 0; i < 16; i++) begin
            exp_push(28'h300 + 28'(4 * i), 32'h1000 + i);
            push1(32'h1000 + i);
        end
        @(negedge clk);
        check("fill_full", {31'h0, user_buffer_full}, 32'd1);
        check("fill_count", {27'h0, dbg_fifo_count}, 32'd16);
        push1(32'hDEAD);
        @(negedge clk);
        check("overflow_count", {27'h0, dbg_fifo_count}, 32'd16);
        acc_start = acc_cnt;
        go(28'h300, 28'd80, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_push(28'h340 + 28'(4 * i), 32'h2000 + i);
            push1(32'h2000 + i);
            @(negedge clk);
            check("pushpop_full", {31'h0, user_buffer_full}, 32'd1);
            check("pushpop_count", {27'h0, dbg_fifo_count}, 32'd16);
        end
        wait_done("pushpop", 40);
        check("pushpop_beats", acc_cnt - acc_start, 32'd20);
        check("pushpop_q_empty", exp_q.size(), 32'd0);
        check("pushpop_drained", {27'h0, dbg_fifo_count}, 32'd0);

        // Underrun: job waits on an empty FIFO
        acc_start = acc_cnt;
        go(28'h200, 28'd12, 1'b0);
        @(negedge clk);
        check("starve_busy", {31'h0, control_done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("starve_write", {31'h0, master_write}, 32'd0);
        end
        exp_push(28'h200, 32'h55);
        push1(32'h55);
        @(negedge clk);
        check("starve_resume", {31'h0, master_write}, 32'd1);
        exp_push(28'h204, 32'h66);
        push1(32'h66);
        exp_push(28'h208, 32'h77);
        push1(32'h77);
        wait_done("starve", 20);
        check("starve_beats", acc_cnt - acc_start, 32'd3);

        // Address wrap plus a go during RUN that must be ignored
        exp_push(28'hFFFFFF8, 32'hC0);
        push1(32'hC0);
        exp_push(28'hFFFFFFC, 32'hC1);
        push1(32'hC1);
        exp_push(28'h0000000, 32'hC2);
        push1(32'hC2);
        exp_push(28'h0000004, 32'hC3);
        push1(32'hC3);
        acc_start = acc_cnt;
        go(28'hFFFFFF8, 28'd16, 1'b0);
        @(negedge clk);
        go(28'h500, 28'd64, 1'b0);
        wait_done("wrap", 20);
        check("wrap_beats", acc_cnt - acc_start, 32'd4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("wrap_idle_done", {31'h0, control_done}, 32'd1);
            check("wrap_idle_write", {31'h0, master_write}, 32'd0);
        end

        // Go with less than one word is ignored
        push1(32'h99);
        acc_start = acc_cnt;
        go(28'h600, 28'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("len3_done", {31'h0, control_done}, 32'd1);
            check("len3_write", {31'h0, master_write}, 32'd0);
        end
        check("len3_beats", acc_cnt - acc_start, 32'd0);
        check("len3_count", {27'h0, dbg_fifo_count}, 32'd1);

        // Reset in the middle of a 16-word job
        for (int i = 0; i < 15; i++) begin
            push1(32'h3000 + i);
        end
        exp_push(28'h700, 32'h99);
        for (int i = 0; i < 15; i++) begin
            exp_push(28'h704 + 28'(4 * i), 32'h3000 + i);
        end
        go(28'h700, 28'd64, 1'b0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        check("postrst_count", {27'h0, dbg_fifo_count}, 32'd0);
        acc_start = acc_cnt;
        go(28'h800, 28'd4, 1'b0);
        @(negedge clk);
        check("postrst_busy", {31'h0, control_done}, 32'd0);
        check("postrst_flushed", {31'h0, master_write}, 32'd0);
        exp_push(28'h800, 32'hBEEF);
        push1(32'hBEEF);
        wait_done("postrst", 20);
        check("postrst_beats", acc_cnt - acc_start, 32'd1);
        check("final_q_empty", exp_q.size(), 32'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_burstless_write_master.md
# mm_burstless_write_master

Avalon-MM write master that services the user-side write control/buffer interface used by `user_logic`. It accepts a transfer command (base, length, fixed_location, go), buffers user data words in an internal FIFO, and issues single-beat word writes on the Avalon-MM fabric (PCIe/SDRAM side) until the byte length is exhausted, then raises done. It replaces the Qsys-generated write master inside the `amm_master_qsys_with_pcie` boundary.

## Interface
Parameters:
- `ADDRESSWIDTH`, 28, byte address width of control base and master address.
- `DATAWIDTH`, 32, data word width; fixed at 32, so one word is 4 bytes.
- `FIFO_DEPTH`, 16, user buffer depth in words; power of 2, ≥ 4.

Ports:
- `clk` in 1: single clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `control_fixed_location` in 1: 1 means every beat goes to the base address.
- `control_write_base` in ADDRESSWIDTH: byte start address; bits [1:0] ignored.
- `control_write_length` in ADDRESSWIDTH: byte count; bits [1:0] ignored.
- `control_go` in 1: single-cycle start pulse.
- `control_done` out 1: high while idle; low while a transfer is active.
- `user_write_buffer` in 1: push `user_buffer_data` into the FIFO.
- `user_buffer_data` in DATAWIDTH: write data word.
- `user_buffer_full` out 1: FIFO holds FIFO_DEPTH words.
- `master_address` out ADDRESSWIDTH: Avalon byte address, word aligned.
- `master_write` out 1: write request.
- `master_byteenable` out 4: constant 4'hF.
- `master_writedata` out DATAWIDTH: FIFO head word.
- `master_waitrequest` in 1: slave stall.

## Operation
- States: IDLE and RUN.
- **IDLE**
  - `control_done`=1.
  - On `control_go`=1 with length[ADDRESSWIDTH-1:2]≠0, load:
    - `addr`←{base[ADDRESSWIDTH-1:2],2'b00}
    - `words`←length>>2
    - `fixed`←control_fixed_location
  - Then go to RUN.
  - Go with word count 0 is ignored; done stays 1.
- **RUN**
  - `control_done`=0. `control_go` is ignored.
  - `master_write`=1 whenever the FIFO is non-empty.
  - A beat is accepted when `master_write`=1 and `master_waitrequest`=0. On acceptance:
    - FIFO pops.
    - `words` decrements.
    - `addr` advances by 4 unless `fixed`.
  - Acceptance with `words`=1 returns the block to IDLE.
- While `master_waitrequest`=1, `master_address` and `master_writedata` hold stable and `master_write` stays high.
- Address arithmetic is modulo 2^ADDRESSWIDTH; 0x...FFC+4 wraps to 0.
- **FIFO**
  - Pushes are accepted in any state, so prefill before go is legal.
  - A push while full is dropped and the count is unchanged.
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Words left in the FIFO after a transfer remain queued for the next transfer.
- **Reset** (async, any time, including mid-transfer): state=IDLE, FIFO flushed.
  - Outputs: `control_done`=1, `master_write`=0, `master_address`=0, `user_buffer_full`=0, `master_writedata`=0.

## Timing
- `control_go` is sampled on the rising edge of `clk`. `control_done` falls the next cycle.
- The first `master_write` can assert the cycle after go if the FIFO is non-empty. Minimum latency from go to first write is 1 cycle.
- A push at edge N makes the word visible on `master_writedata` at N+1 (show-ahead FIFO).
- Throughput is one word per cycle with `master_waitrequest`=0 and no FIFO underrun.
- `control_done` rises the cycle after the last beat is accepted. `master_write` is 0 in that cycle.
- `user_buffer_full` is derived combinationally from the registered count. It reflects a push/pop on the following cycle.
- Underrun (FIFO empty in RUN): `master_write` drops; the block waits with no timeout.

## Structure
- Package `mm_master_pkg`:
  - `wm_state_t` enum {IDLE, RUN}
  - `WORD_BYTES`=4
  - `BYTEENABLE_ALL`=4'hF
- Sub-module `mm_wr_fifo`:
  - Synchronous show-ahead FIFO with parameters DEPTH and WIDTH.
  - Ports: push, pop, din, dout, full, empty, count; async active-low reset flushes it.
- Top module: control FSM, address/word counters, and Avalon output registers.

## Test plan
- **Reset:** hold `n_rst`=0 → `control_done`=1, `master_write`=0, `user_buffer_full`=0. Deassert mid-transfer of a 16-word job → immediate return to those values, FIFO empty.
- **Basic transfer:** prefill 4 words 0x11,0x22,0x33,0x44; go with base 0x100, length 16, fixed=0, no waitrequest → 4 consecutive writes at 0x100,0x104,0x108,0x10C with the data in that order; done high the cycle after the 4th write.
- **Waitrequest stall:** as above but `master_waitrequest`=1 for 3 cycles on beat 2 → address 0x104 and data 0x22 held stable; still exactly 4 acceptances total.
- **Fixed location and truncation:** fixed=1, base 0x0F3, length 11 → 2 writes, both to 0x0F0.
- **FIFO boundaries:** push 17 words while idle → full asserted after the 16th, 17th dropped. In RUN with simultaneous push/pop at full → count stays 16. Starve the FIFO mid-job → write low until the next push.
- **Wrap and ignored go:** base 0xFFFFFF8, length 16 → addresses 0xFFFFFF8, 0xFFFFFFC, 0x0000000, 0x0000004. A second go during RUN has no effect. Go with length 3 → done stays 1, no writes.
